// File: rtl/bht_pkg.sv
// Branch history table shared types and sizing.
// Holds the table geometry, counter encoding and entry layout.
package bht_pkg;

  localparam int BHT_ENTRIES = 64;
  localparam int BHT_IDX_W   = 6;
  localparam int BHT_TAG_W   = 24;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic                 valid;
    logic [BHT_TAG_W-1:0] tag;
    logic [31:0]          target;
    ctr_e                 ctr;
  } bht_entry_t;

endpackage

// File: rtl/bht_sat_ctr.sv
// 2-bit saturating direction counter next-state function.
// Pure combinational; the table owns the state.
module bht_sat_ctr
  import bht_pkg::*;
(
  input  ctr_e ctr,
  input  logic taken,
  output ctr_e ctr_nxt
);

  always_comb begin
    ctr_nxt = ctr;
    unique case (1'b1)
      taken && (ctr != CTR_ST):
        ctr_nxt = ctr_e'(ctr + 2'd1);
      !taken && (ctr != CTR_SNT):
        ctr_nxt = ctr_e'(ctr - 2'd1);
      default: ;
    endcase
  end

endmodule

// File: rtl/bht_predictor.sv
// 64-entry direct-mapped branch predictor with 2-bit counters.
// Optional resolve/mispredict statistics under BHT_STATS_EN.
module bht_predictor
  import bht_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_if_i,
  output logic [31:0] pred_pc_o,
  output logic        pred_taken_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        mispredict_i,
  input  logic        bht_clr_i,
  output logic [31:0] stat_upd_cnt_o,
  output logic [31:0] stat_miss_cnt_o
);

  bht_entry_t tbl [BHT_ENTRIES];

  logic [BHT_IDX_W-1:0] lidx;
  logic [BHT_TAG_W-1:0] ltag;
  bht_entry_t           lent;
  logic                 lhit;

  logic [BHT_IDX_W-1:0] uidx;
  logic [BHT_TAG_W-1:0] utag;
  bht_entry_t           uent;
  logic                 uhit;
  ctr_e                 ctr_nxt;

  logic unused_bits;

  assign lidx = pc_if_i[7:2];
  assign ltag = pc_if_i[31:8];
  assign lent = tbl[lidx];
  assign lhit = lent.valid && (lent.tag == ltag);

  assign pred_taken_o = lhit && lent.ctr[1];
  assign pred_pc_o    = pred_taken_o ? lent.target
                                     : pc_if_i + 32'd4;

  assign uidx = upd_pc_i[7:2];
  assign utag = upd_pc_i[31:8];
  assign uent = tbl[uidx];
  assign uhit = uent.valid && (uent.tag == utag);

  bht_sat_ctr u_ctr (
    .ctr     (uent.ctr),
    .taken   (upd_taken_i),
    .ctr_nxt (ctr_nxt)
  );

  // Clear wins over a same-cycle update; tag/target survive a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        tbl[i] <= '{valid: 1'b0, tag: '0,
                    target: '0, ctr: CTR_WNT};
      end
    end else if (bht_clr_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        tbl[i].valid <= 1'b0;
        tbl[i].ctr   <= CTR_WNT;
      end
    end else if (upd_valid_i) begin
      if (uhit) begin
        tbl[uidx].ctr <= ctr_nxt;
        if (upd_taken_i) begin
          tbl[uidx].target <= upd_target_i;
        end
      end else if (upd_taken_i) begin
        tbl[uidx] <= '{valid: 1'b1, tag: utag,
                       target: upd_target_i,
                       ctr: CTR_WT};
      end
    end
  end

`ifdef BHT_STATS_EN
  logic [31:0] upd_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      upd_cnt  <= '0;
      miss_cnt <= '0;
    end else if (upd_valid_i) begin
      if (upd_cnt != '1) begin
        upd_cnt <= upd_cnt + 32'd1;
      end
      if (mispredict_i && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  assign stat_upd_cnt_o  = upd_cnt;
  assign stat_miss_cnt_o = miss_cnt;
  assign unused_bits = ^{pc_if_i[1:0], upd_pc_i[1:0]};
`else
  assign stat_upd_cnt_o  = '0;
  assign stat_miss_cnt_o = '0;
  assign unused_bits = ^{pc_if_i[1:0], upd_pc_i[1:0],
                         mispredict_i};
`endif

endmodule
